pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register, the general successor of the fixed 32-bit PC/instruction stage register. It carries a DATA_W-bit payload between any two pipeline stages using a valid/ready handshake. A two-entry skid buffer sustains one beat per cycle with a registered back-pressure path. It keeps the stage-register stall and flush controls, drives a configurable bubble value (e.g. NOP) on flush, and provides saturating stall/flush event counters for performance monitoring.

---
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline stage register carrying a DATA_W-bit payload between two
//   pipeline stages. A two-entry skid buffer (main + skid) sustains one beat
//   per cycle while keeping the upstream ready path registered. Stall freezes
//   the stage, flush discards held beats and loads FLUSH_VAL as a bubble.
//   Saturating counters record stall and effective flush cycles.
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rst_i        synchronous active-high reset
//   in_valid_i   upstream beat present
//   in_ready_o   stage can accept a beat this cycle
//   in_data_i    upstream payload
//   stall_i      freeze both sides, contents held
//   flush_i      drop all held beats and any incoming beat
//   out_valid_o  beat available to downstream
//   out_ready_i  downstream accepts
//   out_data_o   payload of the main entry (always driven, stale when empty)
//   stall_cnt_o  cycles with stall_i high, saturating
//   flush_cnt_o  effective flush cycles, saturating
//
// Handshake: a beat transfers on a side in any cycle where that side's valid
// and ready are both 1. A producer holding valid keeps its data stable until
// the transfer; ready never depends combinationally on the same-side valid,
// and in_ready_o has no combinational path from out_ready_i.

module pipe_stage_skid #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              push;
    logic              pop;

    // Occupancy decoded from the valid bits; also the debug view of the stage.
    state_e state_dbg;

    always_comb begin
        state_dbg = ST_EMPTY;
        if (main_v && skid_v) begin
            state_dbg = ST_FULL;
        end else if (main_v) begin
            state_dbg = ST_ONE;
        end
    end

    // Ready comes only from the registered skid_v, so back-pressure from
    // downstream reaches upstream one cycle later.
    assign in_ready_o  = !rst_i && !skid_v && !stall_i;
    assign out_valid_o = main_v && !stall_i && !flush_i;
    assign out_data_o  = main_d;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_d    <= FLUSH_VAL;
            skid_d    <= FLUSH_VAL;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (stall_i) begin
            // Frozen; a concurrent flush is ignored, not deferred.
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end else if (flush_i) begin
            // An incoming beat may still handshake here but is discarded.
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= FLUSH_VAL;
            skid_d <= FLUSH_VAL;
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end else begin
            case (state_dbg)
                ST_EMPTY: begin
                    if (push) begin
                        main_v <= 1'b1;
                        main_d <= in_data_i;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d <= in_data_i;
                    end else if (push) begin
                        skid_v <= 1'b1;
                        skid_d <= in_data_i;
                    end else if (pop) begin
                        // main_d left stale on purpose; only main_v clears.
                        main_v <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready_o is low here, so only a pop can occur.
                    if (pop) begin
                        skid_v <= 1'b0;
                        main_d <= skid_d;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int          DATA_W = 64;
    localparam logic [63:0] FV     = 64'h13;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              flush;
    logic              out_ready;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
    logic              in_ready4;
    logic              out_valid4;
    logic [DATA_W-1:0] out_data4;
    logic [3:0]        stall_cnt4;
    logic [3:0]        flush_cnt4;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 0;

    // Reference model: ordered list of held beats plus counters.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_data;
    int                m_stall;
    int                m_flush;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .FLUSH_VAL(FV), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .FLUSH_VAL(FV), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
        .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_data_o(out_data4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: applies inputs for one cycle, returns at next negedge.
    task automatic dc(input bit r, input bit s, input bit f, input bit v,
                      input logic [63:0] d, input bit rdy);
        rst       = r;
        stall     = s;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit exp_ready;
        bit exp_valid;
        forever begin
            @(negedge clk);
            #2;
            exp_ready = !rst && (exp_q.size() < 2) && !stall;
            exp_valid = (exp_q.size() > 0) && !stall && !flush;
            if (mon_en) begin
                chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
                chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
                chk("out_data", out_data, m_data);
                chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall > 65535 ? 65535 : m_stall));
                chk("flush_cnt", {48'd0, flush_cnt}, 64'(m_flush > 65535 ? 65535 : m_flush));
                chk("stall_cnt4", {60'd0, stall_cnt4}, 64'(m_stall > 15 ? 15 : m_stall));
                chk("flush_cnt4", {60'd0, flush_cnt4}, 64'(m_flush > 15 ? 15 : m_flush));
                chk("out_valid4", {63'd0, out_valid4}, {63'd0, exp_valid});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_beat: got unexpected beat %0h expected none at %0t",
                                 out_data, $time);
                    end else begin
                        chk("sb_beat", out_data, exp_q[0]);
                    end
                end
            end
            // advance the model to the state after the coming posedge
            if (rst) begin
                exp_q.delete();
                m_data  = FV;
                m_stall = 0;
                m_flush = 0;
            end else if (stall) begin
                m_stall++;
            end else if (flush) begin
                exp_q.delete();
                m_data = FV;
                m_flush++;
            end else begin
                if (exp_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_ready) exp_q.push_back(in_data);
                if (exp_q.size() > 0) m_data = exp_q[0];
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        m_data = FV; m_stall = 0; m_flush = 0;
        @(negedge clk);
        dc(1, 0, 0, 0, 0, 1);
        mon_en = 1;
        dc(1, 0, 0, 0, 0, 1);
        chk("reset_data", out_data, 64'h13);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        dc(0, 0, 0, 0, 0, 1);
        chk("reset_ready", {63'd0, in_ready}, 64'd1);

        // back-to-back stream
        for (int i = 1; i <= 8; i++) dc(0, 0, 0, 1, 64'(i), 1);
        dc(0, 0, 0, 0, 0, 1);
        dc(0, 0, 0, 0, 0, 1);

        // back-pressure: A, B absorbed, C held upstream
        dc(0, 0, 0, 1, 64'hA, 0);
        dc(0, 0, 0, 1, 64'hB, 0);
        dc(0, 0, 0, 1, 64'hC, 0);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        chk("full_head", out_data, 64'hA);
        dc(0, 0, 0, 1, 64'hC, 1);
        dc(0, 0, 0, 1, 64'hC, 1);
        dc(0, 0, 0, 0, 0, 1);
        dc(0, 0, 0, 0, 0, 1);

        // refill to FULL, stall 3 cycles with flush in the middle
        dc(0, 0, 0, 1, 64'hE, 0);
        dc(0, 0, 0, 1, 64'hF, 0);
        dc(0, 1, 0, 1, 64'h77, 1);
        dc(0, 1, 1, 1, 64'h77, 1);
        dc(0, 1, 0, 1, 64'h77, 1);
        chk("stall3_cnt", {48'd0, stall_cnt}, 64'd3);
        chk("stall3_flush", {48'd0, flush_cnt}, 64'd0);
        chk("stall3_head", out_data, 64'hE);

        // flush in FULL with an incoming beat D
        dc(0, 0, 1, 1, 64'hD, 1);
        chk("flush_data", out_data, 64'h13);
        chk("flush_cnt1", {48'd0, flush_cnt}, 64'd1);
        dc(0, 0, 0, 0, 0, 1);
        dc(0, 0, 0, 1, 64'h55, 1);
        dc(0, 0, 0, 0, 0, 1);

        // counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) dc(0, 1, 0, 1, {$urandom, $urandom}, 1);
        chk("sat_cnt4", {60'd0, stall_cnt4}, 64'hF);
        chk("sat_cnt16", {48'd0, stall_cnt}, 64'd23);

        // reset mid-stream
        dc(0, 0, 0, 1, 64'h101, 0);
        dc(0, 0, 0, 1, 64'h102, 0);
        dc(1, 0, 0, 1, 64'h103, 1);
        chk("mid_rst_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("mid_rst_data", out_data, 64'h13);
        dc(0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            dc(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 3) != 0),
               {$urandom, $urandom},
               ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) dc(0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
